// File: rtl/uart_block_tx.sv
// uart_block_tx: serialises one 8*BLOCK_BYTES-bit block as BLOCK_BYTES
// consecutive UART frames on tx, most-significant byte first, LSB first
// within each byte. The frame is 8N1 by default.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit (11-bit frames).
// DIV = CLK_HZ/BAUD (truncated) must be at least 2.
module uart_block_tx #(
    parameter int CLK_HZ      = 100_000_000,
    parameter int BAUD        = 9600,
    parameter int BLOCK_BYTES = 8
) (
    input  logic                           clk_100MHz,
    input  logic                           reset,
    input  logic                           start,
    input  logic [8*BLOCK_BYTES-1:0]       block_in,
    output logic                           tx,
    output logic                           busy,
    output logic                           done,
    output logic [$clog2(BLOCK_BYTES)-1:0] byte_idx
);

    localparam int W        = 8 * BLOCK_BYTES;
    localparam int DIV      = CLK_HZ / BAUD;
    localparam int CNT_W    = $clog2(DIV);
    localparam int IDX_W    = $clog2(BLOCK_BYTES);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         bit_cnt;
    logic [W-1:0]       block;     // bytes still waiting, next one at the top
    logic [7:0]         byte_sh;   // byte on the line, current bit in [0]
`ifdef UART_TX_PARITY_EN
    logic               par;       // even parity of the byte on the line
`endif
    logic               tick;
    logic               last;

    assign tick = (cnt == CNT_W'(DIV - 1));
    assign last = (byte_idx == IDX_W'(BLOCK_BYTES - 1));
    assign busy = (state != IDLE);

    // State register; reset aborts any frame in flight immediately.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic: every non-idle state lasts whole bit periods.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = START;
            START:   if (tick) state_next = DATA;
            DATA:    if (tick && bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                         state_next = PARITY;
`else
                         state_next = STOP;
`endif
                     end
            PARITY:  if (tick) state_next = STOP;
            STOP:    if (tick) state_next = last ? IDLE : START;
            default: state_next = IDLE;
        endcase
    end

    // Line level decoded from the state; idle and stop both drive mark (1).
    always_comb begin
        tx = 1'b1;
        case (state)
            START:   tx = 1'b0;
            DATA:    tx = byte_sh[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx = par;
`endif
            default: tx = 1'b1;
        endcase
    end

    // Baud counter, bit/byte sequencing, block capture and done pulse.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            bit_cnt  <= '0;
            block    <= '0;
            byte_sh  <= '0;
            byte_idx <= '0;
            done     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                cnt     <= '0;
                bit_cnt <= '0;
                if (start) begin
                    // block_in is only looked at on this accepting edge
                    byte_sh  <= block_in[W-1 -: 8];
                    block    <= {block_in[W-9:0], 8'h00};
                    byte_idx <= '0;
`ifdef UART_TX_PARITY_EN
                    par      <= ^block_in[W-1 -: 8];
`endif
                end
            end else begin
                cnt <= tick ? '0 : cnt + CNT_W'(1);
                if (tick && state == DATA) begin
                    byte_sh <= byte_sh >> 1;
                    bit_cnt <= bit_cnt + 3'd1;
                end
                if (tick && state == STOP) begin
                    if (last) begin
                        done     <= 1'b1;
                        byte_idx <= '0;
                    end else begin
                        // next frame starts with no idle gap
                        byte_idx <= byte_idx + IDX_W'(1);
                        byte_sh  <= block[W-1 -: 8];
                        block    <= {block[W-9:0], 8'h00};
`ifdef UART_TX_PARITY_EN
                        par      <= ^block[W-1 -: 8];
`endif
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_block_tx.sv
// Directed testbench for uart_block_tx at DIV=10 (1 MHz clock, 100 kbaud).
// The cycle in which start is high is cycle 0 of a block; outputs are
// sampled on the falling edge of each cycle.
module tb_uart_block_tx;

    localparam int CLK_HZ = 1_000_000;
    localparam int BAUD   = 100_000;
    localparam int DIV    = CLK_HZ / BAUD;
`ifdef UART_TX_PARITY_EN
    localparam int FR     = 11;
`else
    localparam int FR     = 10;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [63:0] block_in = '0;
    logic        tx;
    logic        busy;
    logic        done;
    logic [2:0]  byte_idx;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_block_tx #(
        .CLK_HZ(CLK_HZ),
        .BAUD(BAUD),
        .BLOCK_BYTES(8)
    ) dut (
        .clk_100MHz(clk),
        .reset(reset),
        .start(start),
        .block_in(block_in),
        .tx(tx),
        .busy(busy),
        .done(done),
        .byte_idx(byte_idx)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check one whole block starting at cycle 1 (start was set in cycle 0).
    // inj_cyc: pulse start with all-ones data in that cycle (must be ignored).
    // abort_cyc: assert reset mid-cycle in that cycle and stop checking.
    // chain: raise start with next_blk in the done cycle.
    task automatic run_block(input logic [63:0] blk, input int inj_cyc, input int abort_cyc,
                             input logic chain, input logic [63:0] next_blk);
        int cyc;
        logic [7:0] b;
        logic e;
        for (int j = 0; j < 8; j++) begin
            b = blk[63-8*j -: 8];
            for (int i = 0; i < FR; i++) begin
                if (i == 0)           e = 1'b0;
                else if (i <= 8)      e = b[i-1];
                else if (i == FR - 1) e = 1'b1;
                else                  e = ^b;
                for (int k = 0; k < DIV; k++) begin
                    @(negedge clk);
                    cyc = 1 + (j * FR + i) * DIV + k;
                    chk($sformatf("tx_c%0d", cyc), 64'(tx), 64'(e));
                    if (k == 0) begin
                        chk($sformatf("busy_c%0d", cyc), 64'(busy), 64'd1);
                        chk($sformatf("byte_idx_c%0d", cyc), 64'(byte_idx), 64'(j));
                        chk($sformatf("done_c%0d", cyc), 64'(done), 64'd0);
                    end
                    start = 1'b0;
                    if (cyc == inj_cyc) begin
                        start = 1'b1;
                        block_in = '1;
                    end
                    if (cyc == abort_cyc) begin
                        #2 reset = 1'b1;
                        #1;
                        chk("abort_tx", 64'(tx), 64'd1);
                        chk("abort_busy", 64'(busy), 64'd0);
                        chk("abort_done", 64'(done), 64'd0);
                        chk("abort_byte_idx", 64'(byte_idx), 64'd0);
                        return;
                    end
                end
            end
        end
        @(negedge clk);
        chk("end_done", 64'(done), 64'd1);
        chk("end_busy", 64'(busy), 64'd0);
        chk("end_tx", 64'(tx), 64'd1);
        chk("end_byte_idx", 64'(byte_idx), 64'd0);
        start = 1'b0;
        if (chain) begin
            start = 1'b1;
            block_in = next_blk;
        end
    endtask

    initial begin
        // asynchronous reset, observed before any clock edge
        #3 reset = 1'b1;
        #1;
        chk("rst_tx", 64'(tx), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_byte_idx", 64'(byte_idx), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_tx", 64'(tx), 64'd1);
        chk("idle_busy", 64'(busy), 64'd0);

        // single block, then a second block started in the done cycle
        start = 1'b1;
        block_in = 64'h0123456789ABCDEF;
        run_block(64'h0123456789ABCDEF, -1, -1, 1'b1, 64'h1);
        run_block(64'h1, -1, -1, 1'b0, 64'h0);
        @(negedge clk);
        chk("done_pulse_len", 64'(done), 64'd0);
        chk("idle2_busy", 64'(busy), 64'd0);

        // start pulsed mid-block with different data must be ignored
        start = 1'b1;
        block_in = 64'h0123456789ABCDEF;
        run_block(64'h0123456789ABCDEF, 250, -1, 1'b0, 64'h0);
        @(negedge clk);

        // reset during the start bit of byte 3
        start = 1'b1;
        block_in = 64'h0123456789ABCDEF;
        run_block(64'h0123456789ABCDEF, -1, 1 + 3 * FR * DIV + 4, 1'b0, 64'h0);
        @(negedge clk);
        reset = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("post_rst_tx", 64'(tx), 64'd1);
            chk("post_rst_busy", 64'(busy), 64'd0);
            chk("post_rst_done", 64'(done), 64'd0);
        end

        // fresh block after reset goes out from byte 0
        start = 1'b1;
        block_in = 64'hA5A5_A5A5_A5A5_A5A5;
        run_block(64'hA5A5_A5A5_A5A5_A5A5, -1, -1, 1'b0, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
